// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART rx stage. Each rising edge of the level-style
// rx_valid pushes one byte. The output side is first-word fall-through with
// valid/ready, and a sticky overflow flag records dropped bytes.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       m_valid,
  output logic [7:0]                 m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // Handshake: a byte leaves on any rising clk edge where m_valid && m_ready.
  // m_ready is ignored while m_valid is low.

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic [PW-1:0] count_w;
  logic          full_w;
  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  always_comb begin
    rx_valid_d = rx_valid;
    count_w    = wr_ptr_q - rd_ptr_q;
    full_w     = (count_w == DEPTH_P);
    push_req   = rx_valid & ~rx_valid_q;
    pop        = (count_w != '0) & m_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
    push_ok    = push_req & (~full_w | pop);
    push_drop  = push_req & full_w & ~pop;

    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end

    // A drop that coincides with a clear leaves the flag set.
    overflow_d = overflow_q;
    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // rx_valid_q resets high so a level already present at reset release is not a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_valid_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_valid_q <= rx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; m_data is meaningless while m_valid is low.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end
  end

  assign m_valid  = (count_w != '0);
  assign m_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign count    = count_w;
  assign full     = full_w;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. A queue-based reference model tracks the expected
// contents, and a negedge monitor compares the DUT status and the popped bytes.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          ovf_clr;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         m_ovf     = 1'b0;
  bit         m_prev_rx = 1'b1;
  bit         m_push;
  bit         m_drop;
  int         n_checks  = 0;
  int         n_errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of bytes. A new byte arrives on each
  // low-to-high step of rx_valid. It is kept if there is room once this
  // cycle's pop (already taken by the monitor) is accounted for.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf     = 1'b0;
      m_prev_rx = 1'b1;
    end else begin
      m_push    = rx_valid && !m_prev_rx;
      m_prev_rx = rx_valid;
      m_drop    = m_push && (exp_q.size() >= DEPTH);
      if (m_push && !m_drop) exp_q.push_back(rx_data);
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: sample away from the active edge and pop the expected head on a transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("count", count, exp_q.size());
      chk("full", full, exp_q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      if (exp_q.size() != 0) begin
        chk("m_data_head", m_data, exp_q[0]);
        if (m_ready) chk("pop_data", m_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b0;
    cyc();
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int ready_pct;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // A single rising edge of a long-held rx_valid gives exactly one push.
    send_byte(8'hA5);
    chk("hold_count_first", count, 1);
    chk("hold_data_first", m_data, 8'hA5);
    repeat (39) cyc();
    chk("hold_count_40", count, 1);

    // Fill to DEPTH with 0x01..0x10.
    do_reset();
    for (int b = 1; b <= DEPTH; b++) send_byte(8'(b));
    chk("fill_full", full, 1);
    chk("fill_count", count, DEPTH);

    // Push into a full FIFO without a pop: the byte is dropped.
    send_byte(8'h77);
    chk("drop_overflow", overflow, 1);
    chk("drop_count", count, DEPTH);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Push and pop together while full: both accepted.
    rx_valid = 1'b0;
    cyc();
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    m_ready  = 1'b1;
    cyc();
    m_ready  = 1'b0;
    chk("pushpop_full_count", count, DEPTH);
    chk("pushpop_full_ovf", overflow, 0);
    m_ready = 1'b1;
    repeat (DEPTH) cyc();
    chk("drain_count", count, 0);
    chk("drain_valid", m_valid, 0);
    m_ready = 1'b0;

    // Reset in the middle of a cycle clears occupancy at once.
    for (int b = 0; b < 5; b++) send_byte(8'hC0 + 8'(b));
    chk("pre_rst_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ovf", overflow, 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Reset released while rx_valid is already high: no push until low-then-high.
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    do_reset();
    repeat (3) cyc();
    chk("rst_high_no_push", count, 0);
    send_byte(8'h3C);
    chk("rst_high_push_count", count, 1);
    chk("rst_high_push_data", m_data, 8'h3C);

    // Randomized traffic with phases of varying consumer readiness.
    ready_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) ready_pct = $urandom_range(5, 95);
      if (rx_valid) begin
        if ($urandom_range(0, 99) < 50) rx_valid = 1'b0;
      end else if ($urandom_range(0, 99) < 60) begin
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
      end
      m_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr = ($urandom_range(0, 99) < 3);
      cyc();
    end

    // Bounded drain.
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    m_ready  = 1'b1;
    repeat (DEPTH + 4) cyc();
    @(negedge clk);
    #1;
    chk("final_empty_model", exp_q.size(), 0);
    chk("final_empty_dut", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO entries, power of two, 4..256.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_valid  input  1  level valid flag from the rx stage (stays high until next start bit).
REQ-005 SHALL have port rx_data  input  8  received byte, stable while rx_valid high.
REQ-006 SHALL have port m_valid  output  1  FIFO holds at least one byte.
REQ-007 SHALL have port m_data  output  8  head-of-FIFO byte (first-word fall-through).
REQ-008 SHALL have port m_ready  input  1  consumer accepts m_data this cycle.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky: a byte was dropped.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-013 SHALL register rx_valid into rx_valid_q every cycle; push request = rx_valid & ~rx_valid_q (rising edge only, one push per byte regardless of high-level duration).
REQ-014 SHALL write rx_data to mem[wr_ptr] on an accepted push; wr_ptr advances by 1 modulo DEPTH.
REQ-015 SHALL define pop = m_valid & m_ready; rd_ptr advances by 1 modulo DEPTH on pop.
REQ-016 SHALL drive m_valid = (count != 0) and m_data = mem[rd_ptr] combinationally from registered state.
REQ-017 SHALL make a pushed byte visible on m_valid/m_data the cycle after the push edge (1-cycle latency), including when the FIFO was empty.
REQ-018 SHALL keep pointers of $clog2(DEPTH)+1 bits; count = wr_ptr - rd_ptr (unsigned, wrap-around); empty when equal, full when MSBs differ and lower bits equal.
REQ-019 SHALL, on push while full with no pop that cycle, drop the byte, leave mem/pointers unchanged, and set overflow.
REQ-020 SHALL, on push and pop in the same cycle while full, accept both; count stays DEPTH, overflow unchanged.
REQ-021 SHALL, on push and pop in the same cycle while partially filled, accept both; count unchanged.
REQ-022 SHALL ignore m_ready while m_valid is low (no pop when empty, rd_ptr unchanged).
REQ-023 SHALL clear overflow on ovf_clr; if a dropped push and ovf_clr coincide, overflow SHALL be 1 (set wins).
REQ-024 SHALL hold m_data stable while m_valid is high and no pop occurs.

Reset
REQ-025 SHALL on rst_n low asynchronously set wr_ptr=0, rd_ptr=0, overflow=0, rx_valid_q=1; thus count=0, m_valid=0, full=0.
REQ-026 SHALL NOT reset mem contents; m_data is don't-care while m_valid=0.
REQ-027 SHALL reset rx_valid_q to 1 so an rx_valid already high (or unknown-then-high) at reset release produces no push; first push needs a low-then-high transition.
REQ-028 SHALL discard all stored bytes on reset asserted mid-operation; the first post-reset pop returns the first byte pushed after reset.

Verification
REQ-029 SHALL cover: rx_valid pulse low->high with rx_data=0xA5 held high 40 cycles, m_ready=0 -> count=1 next cycle, m_data=0xA5, no second push.
REQ-030 SHALL cover: push 0x01..0x10 (DEPTH=16), then m_ready=1 -> full=1 after 16th push; pops return 0x01..0x10 in order, one per cycle, then m_valid=0, count=0.
REQ-031 SHALL cover: full FIFO, push 0x77 with m_ready=0 -> overflow=1, count=16, 0x77 never popped; ovf_clr pulse -> overflow=0.
REQ-032 SHALL cover: full FIFO, push 0x55 same cycle as pop of head -> count stays 16, 0x55 is the 16th byte popped afterwards, overflow=0.
REQ-033 SHALL cover: rst_n released with rx_valid=1 -> no push; rx_valid 0 then 1 with 0x3C -> exactly one push, m_data=0x3C.
REQ-034 SHALL cover: 5 bytes stored, rst_n pulsed low mid-cycle -> m_valid=0, count=0 immediately (asynchronous), overflow=0.
